alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational ALU in the CPU execute stage.
- Single-cycle ops: ADD, SUB, SLT, SLTU. Iterative ops: MUL (shift-add, full 2W product) and DIVU (restoring divide, quotient and remainder).
- Valid/ready handshakes on both input and output, so the pipeline can stall on long ops.
- Adds flags: zero, signed overflow, error.

Parameters:
- W, 16, operand/result width in bits (W >= 4).
- CW, $clog2(W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- func  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 SLT, 100 SLTU, 101 DIVU, 110/111 illegal.
- src_a  in  W  operand A.
- src_b  in  W  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  W  primary result: sum, difference, product low half, compare bit, or quotient.
- result_hi  out  W  product high half (MUL), remainder (DIVU), 0 otherwise.
- flag_zero  out  1  result == 0.
- flag_ovf  out  1  signed overflow, ADD/SUB only.
- flag_err  out  1  DIVU with src_b == 0, or illegal func.

Behaviour:
- Reset (async, while rst=1): state IDLE; out_valid=0; result, result_hi, flags and counter = 0. in_ready=1 once rst is released.
- Accept: request accepted on a cycle with in_valid & in_ready. Operands and func are captured at the accept cycle and are ignored afterwards.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back single-cycle throughput.
- States:
  - IDLE: on accept of a single-cycle op or illegal func -> DONE. On accept of MUL -> MUL_BUSY. On accept of DIVU with src_b!=0 -> DIV_BUSY. On accept of DIVU with src_b==0 -> DONE.
  - MUL_BUSY / DIV_BUSY: one iteration per cycle, counter runs 0..W-1. After the W-th iteration -> DONE.
  - DONE: out_valid=1. On out_ready: a new accept in the same cycle follows the IDLE rules; with no accept -> IDLE.
- Latency, accept at cycle N:
  - Single-cycle, illegal and divide-by-zero: out_valid at N+1.
  - MUL and DIVU: out_valid at N+1+W.
- Output hold: while out_valid & !out_ready, result, result_hi and flags are held stable. out_valid stays 1 until taken.
- ADD/SUB: W-bit wrap. flag_ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from src_a sign.
- SLT (signed) and SLTU (unsigned): result = {0...,1} or 0.
- MUL: unsigned 2W-bit product; {result_hi, result} = a*b.
- DIVU: unsigned; result = a/b, result_hi = a%b.
- DIVU by zero: result = all ones, result_hi = src_a, flag_err=1, no iteration.
- Illegal func: result = 0, result_hi = 0, flag_err=1, flag_zero=1.
- flag_ovf=0 and flag_err=0 for all ops not listed above. flag_zero is evaluated on result only.
- Reset mid-iteration: the operation is abandoned with no output, and every reset value above applies.
- in_valid during BUSY: the request is not accepted (in_ready=0), and the requester holds it.

Decomposition:
- Package alu_seq_pkg: func localparams (ADD..DIVU), state encoding (IDLE, MUL_BUSY, DIV_BUSY, DONE), DONE_LAT helper.
- Sub-module alu_seq_iter: shared shift-add / restoring-divide datapath with 2W-bit accumulator, start/mode/busy/done interface.
- The top level holds the FSM, the single-cycle ops, the flags and the output registers.

Test Plan:
- W=16, ADD 0x7FFF+0x0001 accepted at N -> at N+1 result=0x8000, flag_ovf=1, flag_zero=0. SUB 0x0005-0x0005 -> result=0, flag_zero=1.
- MUL 0x1234*0x0100 -> in_ready=0 for N+1..N+16; out_valid at N+17 with result=0x3400, result_hi=0x0012.
- DIVU 100/7 -> at N+17 result=14, result_hi=2. DIVU 0x00AB/0 -> at N+1 result=0xFFFF, result_hi=0x00AB, flag_err=1.
- SLT 0xFFFF,0x0001 -> result=1. SLTU on the same operands -> result=0. func=111 -> result=0, flag_err=1.
- Backpressure: ADD result with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Raise out_ready with in_valid held -> next ADD accepted the same cycle, new result at the following cycle.
- Assert rst at N+8 of a MUL -> out_valid=0 and outputs 0 immediately (async). After release, a new ADD completes normally at +1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode values, FSM state encoding and latency helper for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] FUNC_ADD  = 3'b000;
  localparam logic [2:0] FUNC_SUB  = 3'b001;
  localparam logic [2:0] FUNC_MUL  = 3'b010;
  localparam logic [2:0] FUNC_SLT  = 3'b011;
  localparam logic [2:0] FUNC_SLTU = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Cycles from accept to out_valid for a given opcode and operand width.
  function automatic int done_lat(input logic [2:0] f, input logic b_zero, input int w);
    if (f == FUNC_MUL || (f == FUNC_DIVU && !b_zero)) return w + 1;
    return 1;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply (mode 0) or restoring divide (mode 1), one bit per cycle.
module alu_seq_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   opb;
  logic [CW-1:0]  cnt;
  logic           mode_r;
  logic [W:0]     sum;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;

  // lo/hi expose the value after the current iteration so the caller can
  // capture the final answer on the same edge as the last step.
  always_comb begin
    sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    rem_sh = acc[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opb};
    if (!mode_r)
      acc_nxt = {sum, acc[W-1:1]};
    else if (diff[W])
      acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    else
      acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
  end

  assign done = busy && (cnt == CW'(W - 1));
  assign lo   = acc_nxt[W-1:0];
  assign hi   = acc_nxt[2*W-1:W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mode_r <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mode_r <= mode;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc <= {{W{1'b0}}, a};
      opb <= b;
    end else if (busy) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ADD/SUB/SLT/SLTU, iterative MUL/DIVU.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   func,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         flag_zero,
  output logic         flag_ovf,
  output logic         flag_err
);
  state_t state, state_nxt;

  logic         accept;
  logic         load;
  logic         start;
  logic         mode;
  logic [W-1:0] res_nxt;
  logic [W-1:0] hi_nxt;
  logic         ovf_nxt;
  logic         err_nxt;
  logic         it_busy;
  logic         it_done;
  logic [W-1:0] it_lo;
  logic [W-1:0] it_hi;

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic [W-1:0]        sum;
  logic [W-1:0]        dif;

  assign a_s = src_a;
  assign b_s = src_b;
  assign sum = src_a + src_b;
  assign dif = src_a - src_b;

  alu_seq_iter #(.W(W)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a     (src_a),
    .b     (src_b),
    .busy  (it_busy),
    .done  (it_done),
    .lo    (it_lo),
    .hi    (it_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    res_nxt   = '0;
    hi_nxt    = '0;
    ovf_nxt   = 1'b0;
    err_nxt   = 1'b0;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if (state == DONE && out_ready) state_nxt = IDLE;
        if (accept) begin
          state_nxt = DONE;
          load      = 1'b1;
          case (func)
            FUNC_ADD: begin
              res_nxt = sum;
              ovf_nxt = (src_a[W-1] == src_b[W-1]) && (sum[W-1] != src_a[W-1]);
            end
            FUNC_SUB: begin
              res_nxt = dif;
              ovf_nxt = (src_a[W-1] != src_b[W-1]) && (dif[W-1] != src_a[W-1]);
            end
            FUNC_MUL: begin
              state_nxt = MUL_BUSY;
              load      = 1'b0;
              start     = 1'b1;
            end
            FUNC_SLT:  res_nxt = {{(W-1){1'b0}}, (a_s < b_s)};
            FUNC_SLTU: res_nxt = {{(W-1){1'b0}}, (src_a < src_b)};
            FUNC_DIVU: begin
              if (src_b == '0) begin
                res_nxt = '1;
                hi_nxt  = src_a;
                err_nxt = 1'b1;
              end else begin
                state_nxt = DIV_BUSY;
                load      = 1'b0;
                start     = 1'b1;
                mode      = 1'b1;
              end
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (it_done) begin
          state_nxt = DONE;
          load      = 1'b1;
          res_nxt   = it_lo;
          hi_nxt    = it_hi;
        end else if (!it_busy) begin
          // Datapath idle without finishing cannot occur normally; recover rather than hang.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flag_zero <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_err  <= 1'b0;
    end else if (load) begin
      result    <= res_nxt;
      result_hi <= hi_nxt;
      flag_zero <= (res_nxt == '0);
      flag_ovf  <= ovf_nxt;
      flag_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised scoreboard bench for alu_seq at W=16.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [2:0]  flg;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func = 3'b000;
  logic [15:0] src_a = '0;
  logic [15:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        flag_zero;
  logic        flag_ovf;
  logic        flag_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  int   first_cyc = 0;
  exp_t q[$];

  alu_seq #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_zero (flag_zero),
    .flag_ovf  (flag_ovf),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic [15:0] h,
                              input logic z, input logic o, input logic e, input int lat);
    exp_t x;
    x.res = r; x.hi = h; x.flg = {z, o, e}; x.lat = lat; x.acc_cyc = 0;
    return x;
  endfunction

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    int s;
    logic [31:0] aa, bb, p;
    logic ovf, err;
    x.res = '0; x.hi = '0; x.lat = 1; x.acc_cyc = 0;
    ovf = 1'b0; err = 1'b0;
    aa = {16'h0, a}; bb = {16'h0, b};
    case (f)
      FUNC_ADD: begin
        s = int'($signed(a)) + int'($signed(b));
        x.res = a + b; ovf = (s > 32767) || (s < -32768);
      end
      FUNC_SUB: begin
        s = int'($signed(a)) - int'($signed(b));
        x.res = a - b; ovf = (s > 32767) || (s < -32768);
      end
      FUNC_MUL: begin
        p = aa * bb; x.res = p[15:0]; x.hi = p[31:16]; x.lat = 17;
      end
      FUNC_SLT:  x.res = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      FUNC_SLTU: x.res = (aa < bb) ? 16'd1 : 16'd0;
      FUNC_DIVU: begin
        if (b == 16'h0) begin
          x.res = 16'hFFFF; x.hi = a; err = 1'b1;
        end else begin
          p = aa / bb; x.res = p[15:0];
          p = aa % bb; x.hi = p[15:0]; x.lat = 17;
        end
      end
      default: err = 1'b1;
    endcase
    x.flg = {x.res == 16'h0, ovf, err};
    return x;
  endfunction

  // Called at posedge+1; holds the request until accepted, then scrambles the operands.
  task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; func = f; src_a = a; src_b = b;
    #1;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok && push) begin
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; func = 3'(f + 3'd3);
    src_a = 16'($urandom); src_b = 16'($urandom);
  endtask

  task automatic drain();
    int bound;
    bound = done_lat(FUNC_MUL, 1'b0, 16) + 20;
    for (int t = 0; t < bound && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin seen = 1'b1; first_cyc = cyc; end
      if (out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("result",    32'(result),    32'(e.res));
          check("result_hi", 32'(result_hi), 32'(e.hi));
          check("flags_zoe", 32'({flag_zero, flag_ovf, flag_err}), 32'(e.flg));
          check("latency",   32'(first_cyc - e.acc_cyc), 32'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_result_hi", 32'(result_hi), 32'd0);
    check("rst_flags",     32'({flag_zero, flag_ovf, flag_err}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    issue(FUNC_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 16'h0, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    issue(FUNC_SUB, 16'h0005, 16'h0005, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    issue(FUNC_SUB, 16'h8000, 16'h0001, mk(16'h7FFF, 16'h0, 1'b0, 1'b1, 1'b0, 1), 1'b1);
    drain();

    issue(FUNC_MUL, 16'h1234, 16'h0100, mk(16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0, 17), 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("mul_busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("mul_out_valid", 32'(out_valid), 32'd1);
    drain();

    issue(FUNC_DIVU, 16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0, 1'b0, 17), 1'b1);
    issue(FUNC_DIVU, 16'h00AB, 16'h0, mk(16'hFFFF, 16'h00AB, 1'b0, 1'b0, 1'b1, 1), 1'b1);
    issue(FUNC_SLT,  16'hFFFF, 16'h0001, mk(16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    issue(FUNC_SLTU, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b0, 1), 1'b1);
    issue(3'b111,    16'h1234, 16'h5678, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 1), 1'b1);
    issue(3'b110,    16'h0001, 16'h0001, mk(16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 1), 1'b1);
    issue(FUNC_MUL,  16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 17), 1'b1);
    issue(FUNC_DIVU, 16'd3,    16'd10,   mk(16'd0, 16'd3, 1'b1, 1'b0, 1'b0, 17), 1'b1);
    issue(FUNC_DIVU, 16'hFFFF, 16'h0001, mk(16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 17), 1'b1);
    drain();

    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      issue(FUNC_MUL, a, b, model(FUNC_MUL, a, b), 1'b1);
      b = 16'($urandom_range(1, 65535));
      issue(FUNC_DIVU, a, b, model(FUNC_DIVU, a, b), 1'b1);
      issue(FUNC_ADD, a, b, model(FUNC_ADD, a, b), 1'b1);
      issue(FUNC_SUB, b, a, model(FUNC_SUB, b, a), 1'b1);
      issue(FUNC_SLT, a, b, model(FUNC_SLT, a, b), 1'b1);
    end
    drain();

    out_ready = 1'b0;
    issue(FUNC_ADD, 16'd1, 16'd2, mk(16'd3, 16'h0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result",    32'(result),    32'd3);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(FUNC_ADD, 16'd10, 16'd20, mk(16'd30, 16'h0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain();

    issue(FUNC_MUL, 16'h00FF, 16'h0101, mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 17), 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result",    32'(result),    32'd0);
    check("midrst_result_hi", 32'(result_hi), 32'd0);
    check("midrst_flags",     32'({flag_zero, flag_ovf, flag_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(FUNC_ADD, 16'h0100, 16'h0023, mk(16'h0123, 16'h0, 1'b0, 1'b0, 1'b0, 1), 1'b1);
    drain();
    repeat (20) begin @(posedge clk); #1; end
    check("abandoned_mul_silent", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
